// File: rtl/xor_stream_encryptor_if.sv
// Stream and seed-control bundle for xor_stream_encryptor.
// slave: the encryptor side; master: the source/sink side.
interface xor_stream_encryptor_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LFSR_W = 32
) ();
    logic              seed_load;
    logic [LFSR_W-1:0] seed;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       beat_count;

    modport slave (
        input  seed_load, seed, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, beat_count
    );

    modport master (
        output seed_load, seed, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, beat_count
    );
endinterface

// File: rtl/xor_stream_encryptor.sv
// Registered XOR stream encryptor keyed by a Galois LFSR, one-beat output buffer.
// Optional saturating beat counter enabled by defining XOR_ENC_CNT_EN.
module xor_stream_encryptor #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       LFSR_W = 32,
    parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003
) (
    input logic                   clk,
    input logic                   rst,
    xor_stream_encryptor_if.slave bus
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] lfsr_step;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;

    // seed_load wins over an accept, so it also gates in_ready.
    assign bus.in_ready  = !bus.seed_load && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign lfsr_step     = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        lfsr_d      = lfsr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (bus.seed_load) begin
            // All-zero is the LFSR lock-up state.
            lfsr_d      = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
            out_valid_d = 1'b0;
        end else if (accept) begin
            lfsr_d      = lfsr_step;
            out_data_d  = bus.in_data ^ lfsr_q[DATA_W-1:0];
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= LFSR_W'(1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef XOR_ENC_CNT_EN
    logic [31:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q;
        if (bus.seed_load) begin
            beat_count_d = '0;
        end else if (accept && (beat_count_q != 32'hFFFF_FFFF)) begin
            beat_count_d = beat_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign bus.beat_count = beat_count_q;
`else
    assign bus.beat_count = '0;
`endif

endmodule

// File: tb/tb_xor_stream_encryptor.sv
// Directed, table-driven bench for xor_stream_encryptor (either XOR_ENC_CNT_EN build).
module tb_xor_stream_encryptor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    xor_stream_encryptor_if #(.DATA_W(8), .LFSR_W(32)) bus ();

    xor_stream_encryptor #(.DATA_W(8), .LFSR_W(32), .TAPS(32'h80200003)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       in_valid;
        logic       out_ready;
        logic [7:0] in_data;
        logic       exp_in_ready;
        logic       exp_out_valid;
        logic [7:0] exp_out_data;
        int         exp_cnt;
    } vec_t;

    vec_t       vec [12];
    logic [7:0] ct [16];
    logic [31:0] s;

    function automatic int cnt_exp(input int n);
`ifdef XOR_ENC_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sl, input logic [31:0] sd, input logic iv,
                         input logic [7:0] d, input logic ordy);
        bus.seed_load = sl;
        bus.seed      = sd;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        // Stream from reset (S=1), backpressure, then idle draining.
        vec[0]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h01, 1};
        vec[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h03, 2};
        vec[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h02, 3};
        vec[3]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h02, 3};
        vec[4]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h02, 3};
        vec[5]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h02, 3};
        vec[6]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h02, 3};
        vec[7]  = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h54, 4};
        vec[8]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h54, 4};
        vec[9]  = '{1'b1, 1'b0, 8'hA0, 1'b1, 1'b1, 8'hA3, 5};
        vec[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA3, 5};
        vec[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA3, 5};

        drive(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset out_data", {24'd0, bus.out_data}, 32'd0);
        chk("reset beat_count", bus.beat_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'h0, vec[i].in_valid, vec[i].in_data, vec[i].out_ready);
            #1;
            chk($sformatf("vec%0d in_ready", i), {31'd0, bus.in_ready},
                {31'd0, vec[i].exp_in_ready});
            tick();
            chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid},
                {31'd0, vec[i].exp_out_valid});
            chk($sformatf("vec%0d out_data", i), {24'd0, bus.out_data},
                {24'd0, vec[i].exp_out_data});
            chk($sformatf("vec%0d beat_count", i), bus.beat_count, cnt_exp(vec[i].exp_cnt));
        end

        // Zero seed and priority: S is now 0xD8360002, so this beat gets K=0x02.
        drive(1'b0, 32'h0, 1'b1, 8'h00, 1'b0);
        tick();
        chk("pending beat data", {24'd0, bus.out_data}, 32'h02);
        chk("pending beat count", bus.beat_count, cnt_exp(6));
        drive(1'b1, 32'h0, 1'b1, 8'h77, 1'b0);
        #1;
        chk("seed_load in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("seed_load drops beat", {31'd0, bus.out_valid}, 32'd0);
        chk("seed_load clears count", bus.beat_count, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 8'h00, 1'b1);
        tick();
        chk("zero seed first word", {24'd0, bus.out_data}, 32'h01);
        chk("zero seed out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("count after reseed", bus.beat_count, cnt_exp(1));

        // Round trip with seed 0xDEADBEEF: keystream starts 0xEF, 0x74.
        drive(1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
        tick();
        s = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, 8'(i), 1'b1);
            tick();
            ct[i] = bus.out_data;
            chk($sformatf("enc%0d out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("enc%0d data", i), {24'd0, bus.out_data}, {24'd0, 8'(i) ^ s[7:0]});
            s = lfsr_next(s);
        end
        chk("enc first cipher", {24'd0, ct[0]}, 32'hEF);
        chk("enc second cipher", {24'd0, ct[1]}, 32'h75);
        drive(1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'h0, 1'b1, ct[i], 1'b1);
            #1;
            chk($sformatf("dec%0d in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            tick();
            chk($sformatf("dec%0d data", i), {24'd0, bus.out_data}, i);
        end
        chk("count after decrypt", bus.beat_count, cnt_exp(16));

        // Reset mid-stream with a held beat.
        drive(1'b0, 32'h0, 1'b1, 8'hFF, 1'b0);
        tick();
        chk("held before reset", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid reset out_data", {24'd0, bus.out_data}, 32'd0);
        chk("mid reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid reset count", bus.beat_count, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 8'h00, 1'b1);
        tick();
        chk("restart keystream", {24'd0, bus.out_data}, 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xor_stream_encryptor.md
# xor_stream_encryptor

Parametrised, registered XOR stream encryptor: each accepted data beat is XORed with a keystream word from an internal Galois LFSR. The result is presented on a valid/ready output with one-beat buffering. It is the sequential successor to the single-bit combinational XOR cell and sits between the pin/IP data source and the downstream link. Encryption and decryption are the same operation when both ends load the same seed.

## Interface
- DATA_W, 8: data beat width in bits; 1 ≤ DATA_W ≤ LFSR_W.
- LFSR_W, 32: keystream LFSR state width.
- TAPS, 32'h80200003: Galois feedback mask, LFSR_W bits.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load `seed` into the LFSR this cycle.
- seed  in  LFSR_W  LFSR seed value.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input can accept a beat.
- in_data  in  DATA_W  plaintext/ciphertext in.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  DATA_W  XOR result.
- beat_count  out  32  number of accepted beats; see Configuration.

## Operation
- LFSR state S, reset value 1. `seed_load` loads `seed`; a zero seed loads 1 instead, because all-zero is a lock-up state.
- Keystream word K = S[DATA_W-1:0].
- Step function: if S[0]=1, S ← (S>>1) ^ TAPS; otherwise S ← S>>1.
- Accept: when in_valid && in_ready, the output register takes in_data ^ K, out_valid goes to 1, and S steps once.
- S never steps without an accepted beat.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one beat per cycle.
- Output hold: while out_valid && !out_ready, out_data and out_valid are held stable. No accept occurs.
- out_valid clears when out_ready is high and no new beat is accepted in the same cycle.
- seed_load priority: seed_load overrides a same-cycle accept.
  - The beat is not taken and in_ready is 0 that cycle.
  - out_valid clears, dropping any pending beat.
  - beat_count clears.
- rst overrides everything.

## Timing
- Reset values: out_valid=0, out_data=0, beat_count=0, S=1.
- in_ready is 1 on the first cycle after reset.
- Latency: a beat accepted at edge N appears on out_data/out_valid after edge N (one register stage).
- Back-to-back accepts with out_ready held at 1 give a continuous stream with no bubbles.
- Simultaneous out_ready and accept: the old beat leaves and the new beat is loaded on the same edge.
- Reset mid-stream: the pending beat is lost and the keystream restarts from S=1.

## Configuration
- Macro: XOR_ENC_CNT_EN.
- Defined: beat_count increments on every accepted beat. It saturates at 32'hFFFFFFFF and clears on rst or seed_load.
- Undefined: beat_count is tied to 0 and the counter logic is not built.
- The data path is identical in both builds.

## Test plan
- Reset then stream (defaults, seed not loaded): in_data 0x00 ×3 with out_ready=1 → out_data 0x01, 0x03, 0x02 on consecutive cycles. S after the three beats = 0x60180001.
- Round trip: load seed 0xDEADBEEF, encrypt 0x00–0x0F. Reload the same seed and feed the ciphertext → output equals 0x00–0x0F in order.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 → out_data stable, in_ready=0, S unchanged. Releasing out_ready resumes with the next keystream word and no loss or duplication.
- Zero seed and priority: seed_load with seed=0 together with in_valid=1 → beat rejected, out_valid=0, next accept of 0x00 outputs 0x01.
- Counter (XOR_ENC_CNT_EN defined): 5 accepts → beat_count=5; then seed_load → 0. Without the macro, beat_count stays 0 throughout.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_data=0, in_ready=1, keystream restarts at 0x01.
